// File: rtl/speed_ramp_pkg.sv
// Shared definitions for the speed ramp limiter and the PWM drive stage it feeds.
package speed_ramp_pkg;

    localparam int SPEED_W = 6;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_ESTOP   = 2'd1,
        MODE_TRIPPED = 2'd2
    } mode_t;

endpackage

// File: rtl/speed_ramp_if.sv
// Command-side bundle of the speed ramp: targets in, ramped commands and status out.
interface speed_ramp_if
    import speed_ramp_pkg::*;
#(
    parameter int WIDTH = SPEED_W
);

    logic [WIDTH-1:0] target_0;
    logic [WIDTH-1:0] target_1;
    logic             target_valid;
    logic             estop;
    logic [WIDTH-1:0] cmd_0;
    logic [WIDTH-1:0] cmd_1;
    logic             at_target;
    logic             wdog_trip;
    mode_t            mode;

    modport master (
        output target_0, target_1, target_valid, estop,
        input  cmd_0, cmd_1, at_target, wdog_trip, mode
    );

    modport slave (
        input  target_0, target_1, target_valid, estop,
        output cmd_0, cmd_1, at_target, wdog_trip, mode
    );

endinterface

// File: rtl/speed_ramp_ramp_channel.sv
// One slew-limited output channel: steps cmd toward tgt by at most STEP per tick.
module ramp_channel
    import speed_ramp_pkg::*;
#(
    parameter int WIDTH = SPEED_W,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] tgt_nxt,
    output logic [WIDTH-1:0] cmd,
    output logic             at_tgt
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   cmd_x;
    logic [WIDTH:0]   tgt_x;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_dif;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] cmd_nxt;

    // One extra bit so both directions clamp onto the target instead of wrapping.
    assign cmd_x  = {1'b0, cmd};
    assign tgt_x  = {1'b0, tgt};
    assign up_sum = cmd_x + STEP_X;
    assign dn_dif = cmd_x - STEP_X;
    assign up_val = (up_sum > tgt_x) ? tgt : up_sum[WIDTH-1:0];
    assign dn_val = (dn_dif[WIDTH] || (dn_dif < tgt_x)) ? tgt : dn_dif[WIDTH-1:0];

    always_comb begin
        cmd_nxt = cmd;
        if (clr) begin
            cmd_nxt = '0;
        end else if (tick) begin
            if (cmd < tgt) begin
                cmd_nxt = up_val;
            end else if (cmd > tgt) begin
                cmd_nxt = dn_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd    <= '0;
            at_tgt <= 1'b1;
        end else begin
            cmd    <= cmd_nxt;
            at_tgt <= (cmd_nxt == tgt_nxt);
        end
    end

endmodule

// File: rtl/speed_ramp.sv
// Dual-channel slew-rate limiter with emergency stop and command-loss watchdog.
module speed_ramp
    import speed_ramp_pkg::*;
#(
    parameter int WIDTH      = SPEED_W,
    parameter int TICK_DIV   = 1000,
    parameter int STEP       = 1,
    parameter int WDOG_TICKS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    speed_ramp_if.slave bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'((WDOG_TICKS > 0) ? WDOG_TICKS - 1 : 0);
    localparam logic [WW-1:0] WD_MAX   = WW'(WDOG_TICKS);

    logic [PW-1:0]    pre;
    logic             tick;
    logic [WW-1:0]    wcnt;
    logic             wd_hit;
    logic             tv_eff;
    logic             trip;
    mode_t            mode;
    logic [WIDTH-1:0] tgt_0;
    logic [WIDTH-1:0] tgt_1;
    logic [WIDTH-1:0] tgt_0_nxt;
    logic [WIDTH-1:0] tgt_1_nxt;
    logic [WIDTH-1:0] cmd_0;
    logic [WIDTH-1:0] cmd_1;
    logic             at_0;
    logic             at_1;

    assign tick   = (pre == PRE_LAST);
    assign tv_eff = bus.target_valid & ~bus.estop;
    assign wd_hit = (WDOG_TICKS > 0) && tick && !tv_eff && (wcnt == WD_LAST);

    // Priority: estop, then a fresh command, then watchdog expiry.
    always_comb begin
        tgt_0_nxt = tgt_0;
        tgt_1_nxt = tgt_1;
        if (bus.estop) begin
            tgt_0_nxt = '0;
            tgt_1_nxt = '0;
        end else if (tv_eff) begin
            tgt_0_nxt = bus.target_0;
            tgt_1_nxt = bus.target_1;
        end else if (wd_hit) begin
            tgt_0_nxt = '0;
            tgt_1_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre   <= '0;
            wcnt  <= '0;
            trip  <= 1'b0;
            tgt_0 <= '0;
            tgt_1 <= '0;
            mode  <= MODE_RUN;
        end else begin
            pre   <= tick ? '0 : pre + PW'(1);
            tgt_0 <= tgt_0_nxt;
            tgt_1 <= tgt_1_nxt;

            if (tv_eff) begin
                wcnt <= '0;
            end else if ((WDOG_TICKS > 0) && tick && (wcnt != WD_MAX)) begin
                wcnt <= wcnt + WW'(1);
            end

            if (tv_eff) begin
                trip <= 1'b0;
            end else if (wd_hit) begin
                trip <= 1'b1;
            end

            if (bus.estop) begin
                mode <= MODE_ESTOP;
            end else if (tv_eff) begin
                mode <= MODE_RUN;
            end else if (wd_hit) begin
                mode <= MODE_TRIPPED;
            end else if (mode == MODE_ESTOP) begin
                mode <= MODE_RUN;
            end
        end
    end

    ramp_channel #(.WIDTH(WIDTH), .STEP(STEP)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .clr     (bus.estop),
        .tgt     (tgt_0),
        .tgt_nxt (tgt_0_nxt),
        .cmd     (cmd_0),
        .at_tgt  (at_0)
    );

    ramp_channel #(.WIDTH(WIDTH), .STEP(STEP)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .clr     (bus.estop),
        .tgt     (tgt_1),
        .tgt_nxt (tgt_1_nxt),
        .cmd     (cmd_1),
        .at_tgt  (at_1)
    );

    assign bus.cmd_0     = cmd_0;
    assign bus.cmd_1     = cmd_1;
    assign bus.at_target = at_0 & at_1;
    assign bus.wdog_trip = trip;
    assign bus.mode      = mode;

endmodule

// File: doc/speed_ramp.md
Name: speed_ramp

Overview:
- Slew-rate limiter that sits directly upstream of the dual-channel PWM drive stage; its two 6-bit outputs connect to the drive's two speed inputs.
- Latches per-channel target speeds from the command source and steps each output toward its target at a fixed rate, so the drive never sees a step change.
- Also provides an emergency stop and a command-loss watchdog, both of which force the drive to zero.

Parameters:
- WIDTH, 6, bit width of speed targets and outputs (unsigned magnitude, 0..2^WIDTH-1).
- TICK_DIV, 1000, clk cycles per ramp step; must be >= 1.
- STEP, 1, maximum change of an output per tick; must be >= 1.
- WDOG_TICKS, 4096, ticks without target_valid before the watchdog trips; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- target_0  input  WIDTH  requested speed, channel 0.
- target_1  input  WIDTH  requested speed, channel 1.
- target_valid  input  1  single-cycle strobe; both targets are sampled when high.
- estop  input  1  level-sensitive emergency stop.
- cmd_0  output  WIDTH  ramped speed to drive input 0 (registered).
- cmd_1  output  WIDTH  ramped speed to drive input 1 (registered).
- at_target  output  1  high when cmd_0 == tgt_0 and cmd_1 == tgt_1 (registered).
- wdog_trip  output  1  watchdog has fired; sticky until the next target_valid.

Behaviour:
- Clocking and reset: single clock domain, clk; reset is synchronous and active-high on rst.
- Reset values: cmd_0 = cmd_1 = 0, tgt_0 = tgt_1 = 0, prescaler = 0, wdog count = 0, wdog_trip = 0, at_target = 1.
- Reset mid-ramp: takes effect on the next clk edge; outputs go to 0 immediately with no ramp-down.
- Prescaler:
  - Free-running count from 0 to TICK_DIV-1, then wraps to 0.
  - tick is asserted in the cycle the count equals TICK_DIV-1.
  - TICK_DIV = 1 gives a tick every cycle.
- Target latch:
  - When target_valid = 1 (and estop = 0), tgt_0/tgt_1 load target_0/target_1 at the next edge.
  - The same edge clears wdog_trip and resets the wdog count.
- Ramp, on each tick, per channel independently:
  - If cmd < tgt: cmd = min(cmd + STEP, tgt).
  - If cmd > tgt: cmd = max(cmd - STEP, tgt).
  - Otherwise cmd is held.
  - Saturating arithmetic, computed at WIDTH+1 bits: no wrap-around and no overshoot; the output lands exactly on the target.
- Simultaneous target_valid and tick: the step uses the previously latched tgt. The new target affects only the next tick.
- Latency: an output first moves on the first tick edge after the target is latched. Full-scale travel takes ceil((2^WIDTH-1)/STEP) ticks.
- estop (highest priority, beats target_valid and tick):
  - While estop = 1: cmd_0 = cmd_1 = 0 and tgt_0 = tgt_1 = 0 from the next edge, and target_valid is ignored.
  - After estop is released, outputs stay at 0 until a new target_valid arrives.
- Watchdog (WDOG_TICKS > 0):
  - Counts ticks since the last target_valid, saturating at WDOG_TICKS.
  - On reaching WDOG_TICKS: tgt_0 = tgt_1 = 0 and wdog_trip = 1. Outputs then ramp down normally, not abruptly.
- at_target is registered from the post-update values, so it is valid in the same cycle as the new cmd values.
- States: this is a per-channel comparator datapath, not a named state machine. The operating modes are RUN, ESTOP and TRIPPED.
  - RUN -> ESTOP on estop = 1.
  - ESTOP -> RUN when estop = 0 (targets are still 0).
  - RUN -> TRIPPED on watchdog expiry.
  - TRIPPED -> RUN on target_valid.

Decomposition:
- Shared package: SPEED_W = 6 (also used by the drive stage) and the mode encoding {RUN, ESTOP, TRIPPED} for debug visibility.
- One sub-module, ramp_channel: WIDTH and STEP parameters; inputs tick, clr, tgt; outputs cmd and at_tgt. It is instantiated twice.
- The prescaler, watchdog and target latch live in the top level.

Test Plan:
- Ramp up: TICK_DIV=4, STEP=1, from reset apply target_0=10, target_1=0 with a single-cycle target_valid -> cmd_0 increments every 4 cycles, reaches 10 after 10 ticks, at_target rises in the same cycle; cmd_1 stays 0.
- Step larger than remaining distance: STEP=4, cmd_0=10, target_0=12 -> next tick cmd_0=12 (no overshoot to 14). Then target_0=0 -> sequence 8, 4, 0.
- Saturation at full scale: STEP=5, target_0=63 from cmd_0=60 -> cmd_0=63, no wrap. Then target_0=0 from 3 -> cmd_0=0, no underflow to 62.
- Simultaneous target_valid and tick: tgt_0=20, cmd_0=15, pulse target_valid with target_0=5 on a tick cycle -> cmd_0=16 on that edge, 15 on the next tick.
- estop priority: ramping at cmd_0=30, assert estop together with target_valid (target_0=40) -> cmd_0=0 next edge and target ignored. After release, cmd stays 0 until a new target_valid.
- Watchdog: WDOG_TICKS=8, TICK_DIV=2, target_0=6, no further strobes -> wdog_trip=1 after 8 ticks and cmd_0 ramps 6 to 0. A new target_valid clears wdog_trip on the next edge. Also assert rst mid-ramp -> all outputs at reset values next edge.
